mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory/LSU port between two requesters: port 0 = instruction fetch, port 1 = decode data path.
//  Each side uses the core req/valid handshake: req held high until valid; valid held high until req drops.
//  Grants one transaction at a time, latches the request fields, sequences the memory handshake and returns read data to the winner.
// PARAMETERS
//  DATA_WIDTH       32  data bus width
//  ADDR_WIDTH       32  address width
//  BYTE_DATA_WIDTH  4   byte-enable width (DATA_WIDTH/8)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    reset, asynchronous, active-low
//  m0_req/m1_req      in   1 each        transaction request, port 0 / port 1
//  m0_we/m1_we        in   1 each        1 = write
//  m0_addr/m1_addr    in   ADDR_WIDTH    byte address
//  m0_wdata/m1_wdata  in   DATA_WIDTH    write data
//  m0_be/m1_be        in   BYTE_DATA_WIDTH  byte enables
//  m0_valid/m1_valid  out  1 each        transaction done (level, see BEHAVIOUR)
//  m0_rdata/m1_rdata  out  DATA_WIDTH    read data, valid while mX_valid=1
//  mem_req    out  1    request to memory
//  mem_we     out  1    write enable
//  mem_addr   out  ADDR_WIDTH  address
//  mem_wdata  out  DATA_WIDTH  write data
//  mem_be     out  BYTE_DATA_WIDTH  byte enables
//  mem_rdata  in   DATA_WIDTH  read data, sampled when mem_valid=1
//  mem_valid  in   1    memory done; held until mem_req drops
//  busy       out  1    state != S_IDLE
//  grant      out  1    index of the current or last granted port
// BEHAVIOUR
//  Reset (rst=0, async): state=S_IDLE; every output and internal register = 0, including grant and the RR pointer.
//  FSM:
//   S_IDLE: if any mX_req=1, pick a winner, latch we/addr/wdata/be into the mem_* registers and set grant -> S_REQ. Otherwise stay.
//   S_REQ: mem_req=1. On mem_valid=1: capture mem_rdata into the winner's rdata register; mem_req=0 next cycle -> S_RESP.
//   S_RESP: winner's mX_valid=1. Exit to S_IDLE when the winner's req=0 AND mem_valid=0.
//  Latency: req seen in S_IDLE at edge t -> mem_req=1 after t. mem_valid at edge t+n -> mX_valid=1 after t+n.
//  Minimum round trip is 3 cycles idle-to-idle, plus the memory wait.
//  Fields are latched at grant; requesters need not hold addr/data stable afterwards.
//  mX_rdata holds its last captured value until that port's next read. On writes the rdata register is not updated.
//  Loser's req stays pending; it is served on a later S_IDLE pass. No back-to-back grant inside one transaction.
//  Both req in the same cycle: resolved by the arbitration policy (CONFIGURATION).
//  Winner drops req before mem_valid (protocol error): the memory transaction still completes.
//   mX_valid is asserted only if req is high in S_RESP; otherwise go straight S_RESP -> S_IDLE.
//  mem_valid high in S_IDLE or for the non-granted port: ignored.
//  Reset mid-transaction: immediate return to S_IDLE with mem_req=0. The in-flight memory access is abandoned.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. On a tie the port != last grant wins; the RR pointer updates on each grant.
//  MEM_ARB_RR_EN undefined: fixed priority, port 1 (data) always wins ties. Port 0 may starve under continuous data traffic (accepted).
// STRUCTURE
//  Shared config.v: state encodings S_IDLE=0, S_REQ=1, S_RESP=2 (2-bit).
//   It also defines the port indices PORT_FETCH=0 and PORT_DATA=1.
//  Sub-module mem_arb_pick: combinational winner select from (m0_req, m1_req, last_grant).
//   It holds the only `ifdef MEM_ARB_RR_EN.
//  Top holds the FSM, field latches, rdata registers and the grant/RR registers.
// TESTING
//  1. Reset with m1_req=1 held: all outputs 0. Release rst -> mem_req=1 one cycle later, grant=1.
//  2. m0 read addr 0x100, memory answers 0xDEADBEEF after 3 cycles:
//     m0_valid=1 and m0_rdata=0xDEADBEEF next edge; m1_valid stays 0.
//  3. m0 and m1 req on the same cycle:
//     fixed mode serves 1 then 0; RR with last grant=1 serves 0 then 1. Check grant sequence and mem_addr.
//  4. m1 write be=4'b0011, wdata=0x1234 at 0x200: mem_we=1, mem_be=0011, mem_wdata=0x1234 and mem_addr=0x200 for the whole S_REQ.
//     m1_rdata stays unchanged.
//  5. m0 drops req in S_REQ before mem_valid: m0_valid never rises; FSM reaches S_IDLE; busy=0.
//  6. rst asserted while in S_REQ: mem_req=0 and state S_IDLE asynchronously. A new req after release is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encodings, port indices and default bus widths
package mem_arbiter_pkg;

   localparam int DEF_DATA_WIDTH      = 32;
   localparam int DEF_ADDR_WIDTH      = 32;
   localparam int DEF_BYTE_DATA_WIDTH = DEF_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: req/valid transaction bundle, used for both requester ports and the memory port
interface mem_arbiter_if #(
   parameter int AW = mem_arbiter_pkg::DEF_ADDR_WIDTH,
   parameter int DW = mem_arbiter_pkg::DEF_DATA_WIDTH,
   parameter int BW = mem_arbiter_pkg::DEF_BYTE_DATA_WIDTH
);

   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [BW-1:0] be;
   logic          valid;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, be, input valid, rdata);
   modport slave  (input req, we, addr, wdata, be, output valid, rdata);

endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARB_RR_EN selects round-robin, otherwise port 1 wins ties
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic any_req,
   output logic win
);

`ifdef MEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   // on a tie round-robin hands the port to whoever did not win last; otherwise data port wins
   always_comb begin
      any_req = req0 | req1;
      win     = (RR_EN && req0 && req1) ? ~last_grant : (req1 ? PORT_DATA : PORT_FETCH);
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (m0) and data (m1); build option MEM_ARB_RR_EN
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int BYTE_DATA_WIDTH = DATA_WIDTH / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  m0,
   mem_arbiter_if.slave  m1,
   mem_arbiter_if.master mem,
   output logic          busy,
   output logic          grant
);

   state_t state, state_nxt;
   logic   any_req, win, win_req, take;

   mem_arb_pick u_pick (
      .req0       (m0.req),
      .req1       (m1.req),
      .last_grant (grant),
      .any_req    (any_req),
      .win        (win)
   );

   assign take    = (state == S_IDLE) && any_req;
   assign win_req = (grant == PORT_DATA) ? m1.req : m0.req;

   // next state: one transaction at a time, response held until the winner releases req and memory releases valid
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = any_req ? S_REQ : S_IDLE;
         S_REQ:   state_nxt = mem.valid ? S_RESP : S_REQ;
         S_RESP:  state_nxt = (!win_req && !mem.valid) ? S_IDLE : S_RESP;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state register; async reset abandons any in-flight access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // grant doubles as the round-robin pointer; request fields are captured at grant so requesters may move on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant     <= 1'b0;
         mem.we    <= 1'b0;
         mem.addr  <= '0;
         mem.wdata <= '0;
         mem.be    <= '0;
      end else if (take) begin
         grant     <= win;
         mem.we    <= win ? m1.we    : m0.we;
         mem.addr  <= win ? m1.addr  : m0.addr;
         mem.wdata <= win ? m1.wdata : m0.wdata;
         mem.be    <= win ? m1.be    : m0.be;
      end
   end

   // read data is captured for the winner only on reads and then held until that port's next read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0.rdata <= '0;
         m1.rdata <= '0;
      end else if (state == S_REQ && mem.valid && !mem.we) begin
         if (grant == PORT_DATA) m1.rdata <= mem.rdata;
         else                    m0.rdata <= mem.rdata;
      end
   end

   assign mem.req  = (state == S_REQ);
   assign busy     = (state != S_IDLE);
   assign m0.valid = (state == S_RESP) && (grant == PORT_FETCH) && m0.req;
   assign m1.valid = (state == S_RESP) && (grant == PORT_DATA) && m1.req;

endmodule
